// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit.
//   - state_e      : FSM state encoding (also exported on the debug state port)
//   - OP_*         : instruction opcode[6:2] major-opcode codes
//   - ALUOP_*      : ALUOp codes consumed by the ALU control unit
//   - PC_*         : pc_src mux codes
//   - WB_*         : wb_sel mux codes
//   - opcode_legal : legality check of a full 7-bit opcode
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        if (op[1:0] == 2'b11) begin
            case (op[6:2])
                OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control_instret_counter.sv
// Retired-instruction counter.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high clear
//   en    : count enable (one increment per enabled cycle)
//   count : current count, wraps from all-ones to zero silently
module instret_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Inputs : clk, rst (async active-high), opcode[6:0] from IR,
//          mem_ready (memory completes this cycle), branch_taken (ALU flags).
// Outputs: mem_req/mem_we, ir_write/pc_write/reg_write, pc_src, wb_sel,
//          ALUOp, alu_src_a/alu_src_b, retire pulse, instret count,
//          halted/illegal status and the debug state code.
// Memory handshake: a request is outstanding while mem_req=1; it completes
// in the cycle where mem_ready=1 is seen together with mem_req=1.
// mem_ready in any other cycle has no effect.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           pc_src,
    output logic [1:0]           wb_sel,
    output logic [1:0]           ALUOp,
    output logic                 alu_src_a,
    output logic                 alu_src_b,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted,
    output logic                 illegal,
    output logic [2:0]           state
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [4:0] opc;

    assign opc = opcode[6:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        retire    = 1'b0;
        pc_src    = PC_PLUS4;
        wb_sel    = WB_ALU;
        ALUOp     = ALUOP_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        // Reset is asynchronous, so outputs are forced quiet while rst is
        // high rather than waiting for the state register to settle.
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!opcode_legal(opcode)) begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end else if (opc == OP_SYSTEM) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opc)
                        OP_R, OP_IMM: ALUOp = ALUOP_FUNC;
                        OP_BRANCH:    ALUOp = ALUOP_SUB;
                        default:      ALUOp = ALUOP_ADD;
                    endcase
                    // LUI uses rs1 path; the datapath selects x0 there.
                    alu_src_b = !((opc == OP_R) || (opc == OP_BRANCH));
                    alu_src_a = (opc == OP_AUIPC) || (opc == OP_JAL);
                    if ((opc == OP_LOAD) || (opc == OP_STORE)) begin
                        state_d = ST_MEM;
                    end else if (opc == OP_BRANCH) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else if (opc == OP_FENCE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (opc == OP_STORE);
                    if (mem_ready) begin
                        if (opc == OP_STORE) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    if (opc == OP_LOAD)                          wb_sel = WB_MEM;
                    else if ((opc == OP_JAL) || (opc == OP_JALR)) wb_sel = WB_PC4;
                    if (opc == OP_JAL)       pc_src = PC_IMM;
                    else if (opc == OP_JALR) pc_src = PC_ALU;
                    state_d = ST_FETCH;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    instret_counter #(.W(INSTRET_W)) u_instret (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (instret)
    );

    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. The counter is built 4 bits wide so the
// all-ones -> zero wrap is reachable with a handful of retires.
// Each driven cycle pushes the hand-computed control word expected in that
// cycle; the monitor pops and compares at the falling edge. Immediate checks
// around asynchronous reset compare directly in chk_now.
module tb_multicycle_control;

  localparam int IW = 4;
  localparam int WW = 19 + IW;
  localparam int TIMEOUT_NS = 100000;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                         S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          mem_ready, branch_taken;
  logic          mem_req, mem_we, ir_write, pc_write, reg_write, retire;
  logic [1:0]    pc_src, wb_sel, ALUOp;
  logic          alu_src_a, alu_src_b, halted, illegal;
  logic [IW-1:0] instret;
  logic [2:0]    state;
  logic          done = 1'b0;

  multicycle_control #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .pc_src(pc_src), .wb_sel(wb_sel), .ALUOp(ALUOp),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .retire(retire),
    .instret(instret), .halted(halted), .illegal(illegal), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [WW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [IW-1:0] cnt;

  // strb = {mem_req, mem_we, ir_write, pc_write, reg_write, retire}
  function automatic logic [WW-1:0] cw(input logic [2:0] st, input logic [5:0] strb,
                                       input logic [1:0] pcs, input logic [1:0] wbs,
                                       input logic [1:0] aop, input logic sa, input logic sb,
                                       input logic hl, input logic il, input logic [IW-1:0] ic);
    return {st, strb, pcs, wbs, aop, sa, sb, hl, il, ic};
  endfunction

  function automatic logic [WW-1:0] actual();
    return {state, mem_req, mem_we, ir_write, pc_write, reg_write, retire,
            pc_src, wb_sel, ALUOp, alu_src_a, alu_src_b, halted, illegal, instret};
  endfunction

  initial begin
    logic [WW-1:0] e, a;
    string         t;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = actual();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got st=%0d strb=%b pcs=%b wbs=%b aop=%b a=%b b=%b h=%b il=%b ir=%0d, expected st=%0d strb=%b pcs=%b wbs=%b aop=%b a=%b b=%b h=%b il=%b ir=%0d",
                   t, a[WW-1-:3], a[WW-4-:6], a[WW-10-:2], a[WW-12-:2], a[WW-14-:2],
                   a[IW+3], a[IW+2], a[IW+1], a[IW], a[IW-1:0],
                   e[WW-1-:3], e[WW-4-:6], e[WW-10-:2], e[WW-12-:2], e[WW-14-:2],
                   e[IW+3], e[IW+2], e[IW+1], e[IW], e[IW-1:0]);
        end
      end
    end
  end

  // watchdog: the stimulus must finish within the allotted time
  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not complete within %0d ns (state=%0d)",
               TIMEOUT_NS, state);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs just after a rising edge, register the
  // expected word for this cycle, then advance to just past the next edge.
  task automatic cyc(input logic mr, input logic bt, input logic [WW-1:0] w, input string tag);
    mem_ready    = mr;
    branch_taken = bt;
    exp_q.push_back(w);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Immediate comparison, used while rst is held (no clock edge needed).
  task automatic chk_now(input logic [WW-1:0] w, input string tag);
    logic [WW-1:0] a;
    a = actual();
    n_cmp++;
    if (a !== w) begin
      n_bad++;
      $display("FAIL %s (immediate): got %b expected %b", tag, a, w);
    end
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++)
      cyc(1'b0, 1'b0, cw(S_F, 6'b100000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "fetch_wait");
    cyc(1'b1, 1'b0, cw(S_F, 6'b101000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "fetch");
  endtask

  task automatic decode();
    cyc(1'b1, 1'b0, cw(S_D, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "decode");
  endtask

  task automatic wb(input logic [1:0] pcs, input logic [1:0] wbs, input string tag);
    cyc(1'b1, 1'b0, cw(S_W, 6'b000111, pcs, wbs, 2'b00, 0, 0, 0, 0, cnt), tag);
    cnt = cnt + 1'b1;
  endtask

  task automatic alu_instr(input logic [6:0] op, input logic [1:0] aop, input logic sa,
                           input logic sb, input logic [1:0] pcs, input logic [1:0] wbs,
                           input string tag);
    opcode = op;
    fetch(0);
    decode();
    cyc(1'b1, 1'b0, cw(S_E, 6'b000000, 2'b00, 2'b00, aop, sa, sb, 0, 0, cnt), {tag, "_exec"});
    wb(pcs, wbs, {tag, "_wb"});
  endtask

  task automatic branch(input logic bt);
    opcode = 7'b1100011;
    fetch(0);
    decode();
    cyc(1'b0, bt, cw(S_E, 6'b000101, bt ? 2'b01 : 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, cnt),
        bt ? "br_taken_exec" : "br_not_taken_exec");
    cnt = cnt + 1'b1;
  endtask

  task automatic load(input int mwaits);
    opcode = 7'b0000011;
    fetch(0);
    decode();
    cyc(1'b1, 1'b0, cw(S_E, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, cnt), "ld_exec");
    for (int i = 0; i < mwaits; i++)
      cyc(1'b0, 1'b0, cw(S_M, 6'b100000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "ld_mem_wait");
    cyc(1'b1, 1'b0, cw(S_M, 6'b100000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "ld_mem_done");
    wb(2'b00, 2'b01, "ld_wb");
  endtask

  task automatic store_start(input int fwaits);
    opcode = 7'b0100011;
    fetch(fwaits);
    decode();
    cyc(1'b1, 1'b0, cw(S_E, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, cnt), "st_exec");
    cyc(1'b0, 1'b0, cw(S_M, 6'b110000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "st_mem_wait");
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    cnt = '0;
    chk_now(cw(S_F, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    opcode       = 7'b0000000;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    cnt          = '0;
    #2;
    chk_now(cw(S_F, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "reset_state");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    alu_instr(7'b0110011, 2'b10, 0, 0, 2'b00, 2'b00, "add");
    load(3);
    branch(1'b1);
    branch(1'b0);
    store_start(2);
    cyc(1'b1, 1'b0, cw(S_M, 6'b110101, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, cnt), "st_mem_done");
    cnt = cnt + 1'b1;
    alu_instr(7'b0010111, 2'b00, 1, 1, 2'b00, 2'b00, "auipc");
    alu_instr(7'b1100111, 2'b00, 0, 1, 2'b10, 2'b10, "jalr");
    opcode = 7'b0001111;
    fetch(0);
    decode();
    cyc(1'b0, 1'b0, cw(S_E, 6'b000101, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, cnt), "fence_exec");
    cnt = cnt + 1'b1;
    alu_instr(7'b0110111, 2'b00, 0, 1, 2'b00, 2'b00, "lui");
    alu_instr(7'b0010011, 2'b10, 0, 1, 2'b00, 2'b00, "opimm");
    for (int i = 0; i < 5; i++)
      alu_instr(7'b0110011, 2'b10, 0, 0, 2'b00, 2'b00, "add_fill");
    // count is all-ones here; this retire wraps it to zero
    alu_instr(7'b1101111, 2'b00, 1, 1, 2'b01, 2'b10, "jal_wrap");

    // illegal opcode: halts with no retire, instret stays at 0
    opcode = 7'b0000001;
    fetch(0);
    decode();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, cw(S_H, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, cnt), "illegal_halt");
    do_reset("illegal_cleared");

    // SYSTEM: halts with illegal low
    opcode = 7'b1110011;
    fetch(1);
    decode();
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 1'b0, cw(S_H, 6'b000000, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, cnt), "system_halt");
    do_reset("system_cleared");

    // reset while a store waits in MEM
    alu_instr(7'b0110011, 2'b10, 0, 0, 2'b00, 2'b00, "add_pre");
    store_start(0);
    do_reset("store_abandoned");
    alu_instr(7'b0110011, 2'b10, 0, 0, 2'b00, 2'b00, "add_post");

    @(negedge clk);
    #1;
    done = 1'b1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected words never compared", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
